mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the pipelined RV32I core, directly downstream of the execute stage. It takes the execute stage's ALU result as the effective address and the second register operand as store data. It drives a single-outstanding req/ack data-memory port with byte enables, and returns sign- or zero-extended load data. It stalls the upstream pipeline while an access is in flight and drops the request after a bounded wait.

## Interface
- ACK_TIMEOUT, 255: maximum REQ-state cycles without `dmem_ack_i` before bus error; legal range 1..65535.
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid_mem_i  in  1  instruction present in MEM this cycle.
- MemRead_mem_i  in  1  load instruction.
- MemWrite_mem_i  in  1  store instruction.
- funct3_mem_i  in  3  access width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- ALU_result_mem_i  in  32  effective byte address from execute.
- Rd_data2_mem_i  in  32  store data, right-aligned.
- stall_mem_o  out  1  hold all upstream stages.
- load_data_mem_o  out  32  extended load result.
- load_valid_mem_o  out  1  one-cycle pulse: `load_data_mem_o` valid.
- misalign_mem_o  out  1  one-cycle pulse: misaligned access rejected.
- bus_err_mem_o  out  1  one-cycle pulse: ack timeout.
- dmem_req_o  out  1  memory request.
- dmem_we_o  out  1  1 = write.
- dmem_addr_o  out  32  word address, bits [1:0] = 00.
- dmem_wdata_o  out  32  lane-replicated store data.
- dmem_be_o  out  4  byte enables.
- dmem_ack_i  in  1  request accepted/completed this cycle.
- dmem_rdata_i  in  32  read word, valid with ack.

## Operation
- FSM: IDLE, REQ, DONE.
- Start condition: IDLE and `valid_mem_i` and (MemRead or MemWrite) and aligned.
- If MemRead and MemWrite are both set, the access is a read.
- Alignment rule: H/HU requires addr[0] = 0; W requires addr[1:0] = 0.
- Illegal funct3 (011, 110, 111) decodes as W width, zero-extended.
- IDLE:
  - On start: latch word address, we, be, wdata, funct3, addr[1:0]; go to REQ.
  - On misaligned request: pulse `misalign_mem_o`; no access, no stall; stay IDLE.
  - Non-memory instruction: pass through with no stall.
- REQ:
  - `dmem_req_o` = 1; req, addr, we, be, wdata held stable until ack.
  - Wait counter increments each REQ cycle.
  - On ack: capture `dmem_rdata_i`; go to DONE.
  - When the counter reaches ACK_TIMEOUT with no ack: pulse `bus_err_mem_o`; drop req; go to DONE with load data 0.
- DONE:
  - Pulse `load_valid_mem_o` for loads only.
  - Stall released; return to IDLE.
- `stall_mem_o` = start (combinational, IDLE) OR state == REQ.
- Byte enables:
  - B: 0001 << addr[1:0].
  - H: 0011 or 1100 (by addr[1]).
  - W: 1111.
- wdata: B = {4{byte}}, H = {2{half}}, W = word.
- Load extend: select lane by latched addr[1:0]. B/H sign-extend; BU/HU zero-extend.
- `dmem_ack_i` outside REQ is ignored.
- Reset (async, any state): state IDLE; counter 0; all outputs 0. An in-flight request is abandoned immediately.

## Timing
- Zero-wait memory (ack in the first REQ cycle):
  - Cycle T: IDLE, start, stall = 1.
  - Cycle T+1: REQ, req = 1, ack = 1, stall = 1.
  - Cycle T+2: DONE, `load_valid_mem_o` = 1, stall = 0.
- Each wait state adds one cycle.
- Back-to-back accesses: a new start is possible in the cycle after DONE. Minimum 3 cycles per access.
- Outputs `dmem_*`, `load_*`, `misalign_mem_o` and `bus_err_mem_o` are registered. `stall_mem_o` is combinational.
- Bus error asserts in the cycle after the ACK_TIMEOUT-th REQ cycle; `dmem_req_o` = 0 in that same cycle.

## Configuration
- MEM_MISALIGN_TRAP_EN defined: alignment check and `misalign_mem_o` behave as above.
- MEM_MISALIGN_TRAP_EN undefined:
  - `misalign_mem_o` is tied to 0.
  - Every memory op starts; address low bits are truncated to natural alignment (H clears addr[0], W clears addr[1:0]).

## Structure
- Shared package/header `mem_defs`:
  - funct3 width encodings.
  - FSM state encodings.
  - default ACK_TIMEOUT.
- One sub-module, `load_extend`: combinational lane select and sign/zero extension from (rdata, addr[1:0], funct3). It is reused by a future load-forwarding path.

## Test plan
- LW at 0x100, zero-wait, rdata 0xDEADBEEF:
  - stall high 2 cycles.
  - be = 1111, addr = 0x100.
  - load_data = 0xDEADBEEF with load_valid at T+2.
- LB at 0x103, rdata 0x80FF_0000 -> be = 1000, load_data = 0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH at 0x002, data 0x0000ABCD -> we = 1, addr = 0x000, be = 1100, wdata = 0xABCDABCD; 3 ack wait states -> stall high 5 cycles.
- LW at 0x101 with trap enabled -> misalign pulse, no req, no stall. With trap disabled -> req to 0x100, be = 1111.
- ACK_TIMEOUT = 4, ack never asserted -> req high 4 cycles, then bus_err pulse, load_data = 0, stall released.
- rst_n low in the 2nd REQ cycle -> req drops immediately. After release: IDLE, no load_valid, and a new LW completes normally.

Source files
------------

// File: rtl/mem_defs.sv
// Shared definitions for the RV32I memory-access stage: funct3 width codes,
// FSM states and the default request timeout.
package mem_defs;

  localparam int unsigned ACK_TIMEOUT_DEF = 255;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } mem_size_e;

  // Reserved funct3 codes fall through to word width.
  function automatic mem_size_e f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Lane select and sign/zero extension of a read word; shared with the
// load-forwarding path.
module load_extend
  import mem_defs::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // NOTE: every output of a combinational block gets a value on every path
  // (default arm below) so no latch is inferred.
  always_comb begin
    lane_b = rdata[{addr_lo, 3'b000} +: 8];
    lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    data = {{24{lane_b[7]}}, lane_b};
      F3_BU:   data = {24'b0, lane_b};
      F3_H:    data = {{16{lane_h[15]}}, lane_h};
      F3_HU:   data = {16'b0, lane_h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory-access stage: single-outstanding req/ack data port with byte
// enables and bounded wait. Define MEM_MISALIGN_TRAP_EN to reject misaligned ops.
module mem_stage
  import mem_defs::*;
#(
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_mem_i,
  input  logic        MemRead_mem_i,
  input  logic        MemWrite_mem_i,
  input  logic [2:0]  funct3_mem_i,
  input  logic [31:0] ALU_result_mem_i,
  input  logic [31:0] Rd_data2_mem_i,
  output logic        stall_mem_o,
  output logic [31:0] load_data_mem_o,
  output logic        load_valid_mem_o,
  output logic        misalign_mem_o,
  output logic        bus_err_mem_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i
);

  mem_state_e  state, state_nxt;
  mem_size_e   size;
  logic        mem_op, aligned, start, mis_req, timeout;
  logic [1:0]  eff_lo;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt, ext_data;
  logic [15:0] wait_cnt;
  logic [2:0]  f3_q;
  logic [1:0]  lo_q;

  assign size   = f3_size(funct3_mem_i);
  assign mem_op = valid_mem_i && (MemRead_mem_i || MemWrite_mem_i);
  assign aligned = (size == SZ_B) ||
                   (size == SZ_H && !ALU_result_mem_i[0]) ||
                   (size == SZ_W && ALU_result_mem_i[1:0] == 2'b00);

`ifdef MEM_MISALIGN_TRAP_EN
  assign eff_lo = ALU_result_mem_i[1:0];
  assign mis_req = (state == ST_IDLE) && mem_op && !aligned;
`else
  // Without the trap, low address bits are dropped to natural alignment.
  assign eff_lo = (size == SZ_W) ? 2'b00 :
                  (size == SZ_H) ? {ALU_result_mem_i[1], 1'b0} :
                                   ALU_result_mem_i[1:0];
  assign mis_req = 1'b0;
`endif

  assign timeout = (wait_cnt == 16'(ACK_TIMEOUT - 1));

  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = Rd_data2_mem_i;
    case (size)
      SZ_B: begin
        be_nxt    = 4'b0001 << eff_lo;
        wdata_nxt = {4{Rd_data2_mem_i[7:0]}};
      end
      SZ_H: begin
        be_nxt    = eff_lo[1] ? 4'b1100 : 4'b0011;
        wdata_nxt = {2{Rd_data2_mem_i[15:0]}};
      end
      default: ;
    endcase
  end

  load_extend u_load_extend (
    .rdata   (dmem_rdata_i),
    .addr_lo (lo_q),
    .funct3  (f3_q),
    .data    (ext_data)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_REQ;
      ST_REQ:  if (dmem_ack_i || timeout) state_nxt = ST_DONE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
`ifdef MEM_MISALIGN_TRAP_EN
    start = (state == ST_IDLE) && mem_op && aligned;
`else
    start = (state == ST_IDLE) && mem_op;
`endif
    stall_mem_o = start || (state == ST_REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_req_o       <= 1'b0;
      dmem_we_o        <= 1'b0;
      dmem_addr_o      <= '0;
      dmem_wdata_o     <= '0;
      dmem_be_o        <= '0;
      load_data_mem_o  <= '0;
      load_valid_mem_o <= 1'b0;
      misalign_mem_o   <= 1'b0;
      bus_err_mem_o    <= 1'b0;
      wait_cnt         <= '0;
      f3_q             <= '0;
      lo_q             <= '0;
    end else begin
      load_valid_mem_o <= 1'b0;
      misalign_mem_o   <= mis_req;
      bus_err_mem_o    <= 1'b0;
      case (state)
        ST_IDLE: begin
          wait_cnt <= '0;
          if (start) begin
            dmem_req_o   <= 1'b1;
            // A op flagged as both load and store is treated as a load.
            dmem_we_o    <= MemWrite_mem_i && !MemRead_mem_i;
            dmem_addr_o  <= {ALU_result_mem_i[31:2], 2'b00};
            dmem_be_o    <= be_nxt;
            dmem_wdata_o <= wdata_nxt;
            f3_q         <= funct3_mem_i;
            lo_q         <= eff_lo;
          end
        end
        ST_REQ: begin
          if (dmem_ack_i) begin
            dmem_req_o       <= 1'b0;
            load_valid_mem_o <= !dmem_we_o;
            if (!dmem_we_o) load_data_mem_o <= ext_data;
          end else if (timeout) begin
            dmem_req_o       <= 1'b0;
            bus_err_mem_o    <= 1'b1;
            load_valid_mem_o <= !dmem_we_o;
            load_data_mem_o  <= '0;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage (ACK_TIMEOUT = 4); honours
// MEM_MISALIGN_TRAP_EN for the misaligned-access expectations.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] alu_result, rd_data2;
  logic        stall, load_valid, misalign, bus_err;
  logic [31:0] load_data;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;

  int checks = 0;
  int errors = 0;

  // Results captured by the access task.
  int          stall_cnt, req_cnt;
  logic        got_we, got_lv, got_berr, got_mis;
  logic [31:0] got_addr, got_wdata, got_ld;
  logic [3:0]  got_be;

  always #5 clk = ~clk;

  mem_stage #(.ACK_TIMEOUT(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .valid_mem_i      (valid),
    .MemRead_mem_i    (mem_read),
    .MemWrite_mem_i   (mem_write),
    .funct3_mem_i     (funct3),
    .ALU_result_mem_i (alu_result),
    .Rd_data2_mem_i   (rd_data2),
    .stall_mem_o      (stall),
    .load_data_mem_o  (load_data),
    .load_valid_mem_o (load_valid),
    .misalign_mem_o   (misalign),
    .bus_err_mem_o    (bus_err),
    .dmem_req_o       (dmem_req),
    .dmem_we_o        (dmem_we),
    .dmem_addr_o      (dmem_addr),
    .dmem_wdata_o     (dmem_wdata),
    .dmem_be_o        (dmem_be),
    .dmem_ack_i       (dmem_ack),
    .dmem_rdata_i     (dmem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Issue one instruction and run it until the stage neither stalls nor
  // requests; ack is given after `waits` wait states.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int waits, input logic [31:0] rdata);
    int  n;
    bit  done;
    @(negedge clk);
    valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3;
    alu_result = addr; rd_data2 = wd; dmem_rdata = rdata; dmem_ack = 1'b0;
    stall_cnt = 0; req_cnt = 0; got_mis = 1'b0; done = 1'b0; n = 0;
    got_we = 1'b0; got_addr = '0; got_wdata = '0; got_be = '0;
    got_lv = 1'b0; got_ld = '0; got_berr = 1'b0;
    #1;
    if (stall) stall_cnt++;
    while (!done && n < 50) begin
      @(posedge clk);
      #1;
      n++;
      if (misalign) got_mis = 1'b1;
      if (dmem_req) begin
        req_cnt++;
        if (req_cnt == 1) begin
          got_we = dmem_we; got_addr = dmem_addr;
          got_wdata = dmem_wdata; got_be = dmem_be;
        end
        dmem_ack = (req_cnt > waits);
      end else begin
        dmem_ack = 1'b0;
      end
      if (stall) stall_cnt++;
      if (!dmem_req && !stall) begin
        done = 1'b1;
        got_lv = load_valid; got_ld = load_data; got_berr = bus_err;
      end
    end
    valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; dmem_ack = 1'b0;
    if (!done) check("access_hang", 32'd0, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    funct3 = 3'b000; alu_result = '0; rd_data2 = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_req",   32'(dmem_req),   32'd0);
    check("rst_stall", 32'(stall),      32'd0);
    check("rst_lv",    32'(load_valid), 32'd0);
    check("rst_ld",    load_data,       32'd0);
    check("rst_be",    32'(dmem_be),    32'd0);
    check("rst_berr",  32'(bus_err),    32'd0);
    rst_n = 1'b1;

    // LW 0x100, zero wait.
    access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF);
    check("lw_stall", 32'(stall_cnt), 32'd2);
    check("lw_be",    32'(got_be),    32'hF);
    check("lw_addr",  got_addr,       32'h100);
    check("lw_we",    32'(got_we),    32'd0);
    check("lw_lv",    32'(got_lv),    32'd1);
    check("lw_ld",    got_ld,         32'hDEADBEEF);

    // LB / LBU at 0x103.
    access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80FF_0000);
    check("lb_be", 32'(got_be), 32'h8);
    check("lb_ld", got_ld,      32'hFFFFFF80);
    access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 0, 32'h80FF_0000);
    check("lbu_ld", got_ld, 32'h00000080);

    // LH at 0x002 selects the upper half and sign-extends.
    access(1'b1, 1'b0, 3'b001, 32'h002, 32'h0, 1, 32'h8001_1234);
    check("lh_be",    32'(got_be),    32'hC);
    check("lh_ld",    got_ld,         32'hFFFF8001);
    check("lh_stall", 32'(stall_cnt), 32'd3);

    // SH 0x002 with 3 wait states.
    access(1'b0, 1'b1, 3'b001, 32'h002, 32'h0000ABCD, 3, 32'h0);
    check("sh_we",    32'(got_we),    32'd1);
    check("sh_addr",  got_addr,       32'h000);
    check("sh_be",    32'(got_be),    32'hC);
    check("sh_wdata", got_wdata,      32'hABCDABCD);
    check("sh_stall", 32'(stall_cnt), 32'd5);
    check("sh_lv",    32'(got_lv),    32'd0);

    // SB 0x001 replicates the byte.
    access(1'b0, 1'b1, 3'b000, 32'h001, 32'hFFFF_FF12, 0, 32'h0);
    check("sb_be",    32'(got_be), 32'h2);
    check("sb_wdata", got_wdata,   32'h12121212);

    // Read+write both set behaves as a load.
    access(1'b1, 1'b1, 3'b010, 32'h040, 32'h5555_5555, 0, 32'h0BAD_F00D);
    check("rw_we", 32'(got_we), 32'd0);
    check("rw_ld", got_ld,      32'h0BAD_F00D);

    // Misaligned LW at 0x101.
    access(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 0, 32'h1111_2222);
`ifdef MEM_MISALIGN_TRAP_EN
    check("mis_pulse", 32'(got_mis),   32'd1);
    check("mis_req",   32'(req_cnt),   32'd0);
    check("mis_stall", 32'(stall_cnt), 32'd0);
`else
    check("mis_pulse", 32'(got_mis), 32'd0);
    check("mis_addr",  got_addr,     32'h100);
    check("mis_be",    32'(got_be),  32'hF);
    check("mis_ld",    got_ld,       32'h1111_2222);
`endif

    // Timeout: ack never arrives.
    access(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 100, 32'hFFFF_FFFF);
    check("to_req",   32'(req_cnt),   32'd4);
    check("to_berr",  32'(got_berr),  32'd1);
    check("to_ld",    got_ld,         32'd0);
    check("to_stall", 32'(stall_cnt), 32'd5);

    // Reset in the 2nd REQ cycle.
    @(negedge clk);
    valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010;
    alu_result = 32'h300; dmem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rr_req_before", 32'(dmem_req), 32'd1);
    rst_n = 1'b0; valid = 1'b0; mem_read = 1'b0;
    #1;
    check("rr_req_drop", 32'(dmem_req),   32'd0);
    check("rr_lv",       32'(load_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rr_idle_lv", 32'(load_valid | dmem_req | stall), 32'd0);
    end
    access(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 0, 32'h1234_5678);
    check("rr_lw_ld",    got_ld,         32'h1234_5678);
    check("rr_lw_lv",    32'(got_lv),    32'd1);
    check("rr_lw_stall", 32'(stall_cnt), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
